// File: rtl/chaos_pkg.sv
// Shared definitions for the chaotic-seeded LFSR whitener: state encoding
// and the default LFSR geometry.
package chaos_pkg;

  localparam int          CHAOS_LFSR_W       = 16;
  localparam logic [15:0] CHAOS_TAPS         = 16'h002D;
  localparam logic [15:0] CHAOS_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/lfsr_step.sv
// One Fibonacci LFSR step with an injected perturbation bit; an all-zero
// result is replaced by the default seed so the generator can never lock up.
module lfsr_step
  import chaos_pkg::*;
#(
  parameter int              W            = CHAOS_LFSR_W,
  parameter logic [W-1:0]    TAPS         = W'(CHAOS_TAPS),
  parameter logic [W-1:0]    DEFAULT_SEED = W'(CHAOS_DEFAULT_SEED)
) (
  input  logic [W-1:0] lfsr_i,
  input  logic         p_i,
  output logic [W-1:0] lfsr_next_o,
  output logic         out_bit_o
);

  logic         fb;
  logic [W-1:0] shifted;

  assign fb          = (^(lfsr_i & TAPS)) ^ p_i;
  assign shifted     = {fb, lfsr_i[W-1:1]};
  assign lfsr_next_o = (shifted == '0) ? DEFAULT_SEED : shifted;
  assign out_bit_o   = lfsr_i[0];

endmodule

// File: rtl/chaos_lfsr_whitener.sv
// Whitens chaotic-map samples: seeds an LFSR from a few samples, then steps it
// once per sample (perturbed by sample parity) and packs output bits into words.
module chaos_lfsr_whitener
  import chaos_pkg::*;
#(
  parameter int                 LFSR_W       = CHAOS_LFSR_W,
  parameter logic [LFSR_W-1:0]  TAPS         = LFSR_W'(CHAOS_TAPS),
  parameter logic [LFSR_W-1:0]  DEFAULT_SEED = LFSR_W'(CHAOS_DEFAULT_SEED),
  parameter int                 SEED_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] chaos_in,
  input  logic              chaos_valid,
  output logic              chaos_ready,
  input  logic              start,
  input  logic              stop,
  output logic [LFSR_W-1:0] rnd_word,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              busy
);

  localparam int                BIT_CW    = $clog2(LFSR_W);
  localparam int                SEED_CW   = $clog2(SEED_CYCLES + 1);
  localparam logic [BIT_CW-1:0] BIT_LAST  = BIT_CW'(LFSR_W - 1);
  localparam logic [SEED_CW-1:0] SEED_LAST = SEED_CW'(SEED_CYCLES - 1);

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [LFSR_W-1:0]   acc_q, acc_d;
  logic [BIT_CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SEED_CW-1:0]  seed_cnt_q, seed_cnt_d;
  logic [LFSR_W-1:0]   rnd_word_q, rnd_word_d;
  logic                rnd_valid_q, rnd_valid_d;

  logic [LFSR_W-1:0]   step_lfsr;
  logic                step_bit;
  logic [LFSR_W-1:0]   seed_mix;
  logic                in_xfer;
  logic                out_xfer;

  lfsr_step #(
    .W           (LFSR_W),
    .TAPS        (TAPS),
    .DEFAULT_SEED(DEFAULT_SEED)
  ) u_step (
    .lfsr_i     (lfsr_q),
    .p_i        (^chaos_in[3:0]),
    .lfsr_next_o(step_lfsr),
    .out_bit_o  (step_bit)
  );

  // In RUN the block stalls only when the finishing bit would overwrite an unread word.
  always_comb begin
    chaos_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        SEED:    chaos_ready = 1'b1;
        RUN:     chaos_ready = !(bit_cnt_q == BIT_LAST && rnd_valid_q && !rnd_ready);
        default: chaos_ready = 1'b0;
      endcase
    end
  end

  assign in_xfer  = chaos_valid && chaos_ready;
  assign out_xfer = rnd_valid_q && rnd_ready;
  assign seed_mix = lfsr_q ^ chaos_in;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    acc_d       = acc_q;
    bit_cnt_d   = bit_cnt_q;
    seed_cnt_d  = seed_cnt_q;
    rnd_word_d  = rnd_word_q;
    rnd_valid_d = rnd_valid_q && !out_xfer;

    if (stop && state_q != IDLE) begin
      // A sample offered alongside stop is dropped; the output word survives.
      state_d    = IDLE;
      seed_cnt_d = '0;
      bit_cnt_d  = '0;
      acc_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop) state_d = SEED;
        end
        SEED: begin
          if (in_xfer) begin
            if (seed_cnt_q == SEED_LAST) begin
              state_d    = RUN;
              seed_cnt_d = '0;
              lfsr_d     = (seed_mix == '0) ? DEFAULT_SEED : seed_mix;
            end else begin
              seed_cnt_d = seed_cnt_q + SEED_CW'(1);
              lfsr_d     = seed_mix;
            end
          end
        end
        RUN: begin
          if (in_xfer) begin
            lfsr_d    = step_lfsr;
            acc_d     = {acc_q[LFSR_W-2:0], step_bit};
            bit_cnt_d = bit_cnt_q + BIT_CW'(1);
            if (bit_cnt_q == BIT_LAST) begin
              rnd_word_d  = {acc_q[LFSR_W-2:0], step_bit};
              rnd_valid_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lfsr_q      <= DEFAULT_SEED;
      acc_q       <= '0;
      bit_cnt_q   <= '0;
      seed_cnt_q  <= '0;
      rnd_word_q  <= '0;
      rnd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      acc_q       <= acc_d;
      bit_cnt_q   <= bit_cnt_d;
      seed_cnt_q  <= seed_cnt_d;
      rnd_word_q  <= rnd_word_d;
      rnd_valid_q <= rnd_valid_d;
    end
  end

  assign rnd_word  = rnd_word_q;
  assign rnd_valid = rnd_valid_q;
  assign busy      = (state_q != IDLE);

endmodule
